tdc_rx_collector: RTL and testbench
===================================

TDC_RX_COLLECTOR -- requirements
Module: tdc_rx_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, 4..32.
REQ-002 SHALL have ports: clk  input  1  logic clock, 250 MHz domain of the TDC output stream.
REQ-003 SHALL have ports: rst_auto  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: TDC_Odata  input  15  depth code of current beat.
REQ-005 SHALL have ports: TDC_Oint  input  4  intensity count of current beat.
REQ-006 SHALL have ports: TDC_Onum  input  2  beats in current frame minus 1, held constant across the frame.
REQ-007 SHALL have ports: TDC_Olast  input  1  marks final beat of frame.
REQ-008 SHALL have ports: TDC_Ovalid  input  1  beat valid.
REQ-009 SHALL have ports: TDC_Oready  output  1  collector can accept a beat.
REQ-010 SHALL have ports: TDC_INT  input  1  TDC interrupt level.
REQ-011 SHALL have ports: TDC_Range  input  15  max legal depth code.
REQ-012 SHALL have ports: rd_en  input  1  host pop request.
REQ-013 SHALL have ports: rd_data  output  20  {oor, Oint[3:0], Odata[14:0]} of FIFO head, first-word-fall-through.
REQ-014 SHALL have ports: rd_empty  output  1  FIFO empty.
REQ-015 SHALL have ports: frame_done  output  1  one-cycle pulse per completed frame.
REQ-016 SHALL have ports: frame_cnt  output  8  completed-frame counter.
REQ-017 SHALL have ports: err_len  output  1  sticky beat-count mismatch flag.
REQ-018 SHALL have ports: irq  output  1  sticky interrupt pending.
REQ-019 SHALL have ports: irq_clr  input  1  clears irq and err_len.

Function
REQ-020 SHALL accept a beat on a clk rising edge only when TDC_Ovalid=1 and TDC_Oready=1.
REQ-021 SHALL drive TDC_Oready = !full, from registered FIFO count with no combinational path from TDC_Ovalid.
REQ-022 SHALL write accepted beats to the FIFO tail; oor=1 when TDC_Odata > TDC_Range (unsigned compare), else 0; entry visible on rd_data the cycle after acceptance.
REQ-023 SHALL pop the head on rd_en=1 when rd_empty=0; rd_en when empty is ignored, with no pointer change.
REQ-024 SHALL keep the count unchanged on simultaneous accept and pop; accept and pop in the same cycle is legal only when not full.
REQ-025 SHALL implement FSM IDLE/RECV/DONE: IDLE->RECV on accepted beat with Olast=0; IDLE->DONE on accepted beat with Olast=1; RECV->DONE on accepted Olast beat; DONE->IDLE unconditionally after 1 cycle.
REQ-026 SHALL run a 3-bit beat counter, cleared in IDLE, incremented per accepted beat, saturating at 7.
REQ-027 SHALL capture TDC_Onum on the first beat of a frame; on the Olast beat, if (count incl. last) != captured Onum+1, set err_len.
REQ-028 SHALL set err_len if TDC_Onum changes mid-frame.
REQ-029 SHALL pulse frame_done for exactly the DONE cycle.
REQ-030 SHALL increment frame_cnt in DONE, wrapping 255->0.
REQ-031 SHALL set irq on a TDC_INT rising edge, detected with a registered previous value.
REQ-032 SHALL clear irq and err_len on irq_clr=1; a set event in the same cycle as irq_clr wins.
REQ-033 SHALL not drop or duplicate data; backpressure is the only flow control.

Reset
REQ-034 SHALL, while rst_auto=0: TDC_Oready=0, rd_empty=1, rd_data=0, frame_done=0, frame_cnt=0, err_len=0, irq=0, FSM=IDLE, pointers/counts=0, TDC_INT edge register=0.
REQ-035 SHALL discard a partial frame and all FIFO contents when reset asserts mid-frame; the first beat after release starts a new frame.
REQ-036 SHALL raise TDC_Oready on the first clk edge after rst_auto deasserts.

Verification
REQ-037 SHALL verify single beat: Odata=0x0FFC, Oint=3, Onum=0, Olast=1, Range=0x03FC -> rd_data={1,3,0x0FFC}, frame_done one pulse, frame_cnt=1, err_len=0.
REQ-038 SHALL verify 4-beat frame with Onum=3, Olast on 4th beat -> 4 entries in order, one frame_done, err_len=0; same with Olast on 3rd beat -> err_len=1.
REQ-039 SHALL verify backpressure: DEPTH=8, rd_en=0, 9 valid beats -> TDC_Oready=0 after 8th, 9th held; one pop -> 9th accepted next cycle, no loss.
REQ-040 SHALL verify concurrency: continuous rd_en with valid every cycle -> occupancy stays at 1 and output order matches input order.
REQ-041 SHALL verify wrap and irq: 256 frames -> frame_cnt=0; TDC_INT 0->1 -> irq=1; irq_clr with a simultaneous TDC_INT edge -> irq stays 1.
REQ-042 SHALL verify mid-frame reset: rst_auto low after 2 of 4 beats -> rd_empty=1, frame_cnt=0; the next 1-beat frame completes with err_len=0.

Source files
------------

// File: rtl/tdc_rx_collector.sv
// TDC beat collector: frames beats, checks length, queues {oor,int,depth} in a FWFT FIFO; entry readable 1 cycle after accept.
// Backpressure: TDC_Oready is a flop tracking !full, so a beat is held upstream while the FIFO is full.
module tdc_rx_collector #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_auto,
  input  logic [14:0] TDC_Odata,
  input  logic [3:0]  TDC_Oint,
  input  logic [1:0]  TDC_Onum,
  input  logic        TDC_Olast,
  input  logic        TDC_Ovalid,
  output logic        TDC_Oready,
  input  logic        TDC_INT,
  input  logic [14:0] TDC_Range,
  input  logic        rd_en,
  output logic [19:0] rd_data,
  output logic        rd_empty,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        err_len,
  output logic        irq,
  input  logic        irq_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q, rdy_d;
  logic          int_prev_q, int_prev_d;
  logic          irq_q, irq_d;

  state_t        state_q;
  logic [2:0]    beat_cnt_q;
  logic [1:0]    onum_q;
  logic          frame_done_q;
  logic [7:0]    frame_cnt_q;
  logic          err_len_q;

  logic          accept;
  logic          pop;
  logic          empty;
  logic          oor;
  logic [19:0]   wdat;
  logic [2:0]    beat_inc;
  logic          err_set;

  assign empty    = (count_q == '0);
  assign accept   = TDC_Ovalid & rdy_q;
  assign pop      = rd_en & ~empty;
  assign oor      = (TDC_Odata > TDC_Range);
  assign wdat     = {oor, TDC_Oint, TDC_Odata};
  assign beat_inc = (beat_cnt_q == 3'd7) ? 3'd7 : beat_cnt_q + 3'd1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Ready is registered from the next count so upstream never sees a path from its own valid.
    rdy_d      = (count_d != FULL_CNT);
    int_prev_d = TDC_INT;
    irq_d      = (TDC_INT & ~int_prev_q) | (irq_q & ~irq_clr);
  end

  always_comb begin
    err_set = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: if (TDC_Olast && (TDC_Onum != 2'd0)) err_set = 1'b1;
        RECV: begin
          if (TDC_Onum != onum_q) err_set = 1'b1;
          if (TDC_Olast && (beat_inc != ({1'b0, onum_q} + 3'd1))) err_set = 1'b1;
        end
        default: err_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_auto) begin
    if (!rst_auto) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
      int_prev_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdy_q      <= rdy_d;
      int_prev_q <= int_prev_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_auto) begin
    if (!rst_auto) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      onum_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_len_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_len_q    <= err_set | (err_len_q & ~irq_clr);
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (accept) begin
            beat_cnt_q <= 3'd1;
            onum_q     <= TDC_Onum;
            if (TDC_Olast) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (accept) begin
            beat_cnt_q <= beat_inc;
            if (TDC_Olast) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TDC_Oready = rdy_q;
  assign rd_empty   = empty;
  assign rd_data    = empty ? 20'd0 : mem_q[rd_ptr_q];
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_len    = err_len_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_tdc_rx_collector.sv
// Directed bench for tdc_rx_collector: framing, length errors, FIFO flow control, counter wrap, irq.
module tb_tdc_rx_collector;
  logic        clk = 1'b0;
  logic        rst_auto = 1'b0;
  logic [14:0] TDC_Odata = '0;
  logic [3:0]  TDC_Oint = '0;
  logic [1:0]  TDC_Onum = '0;
  logic        TDC_Olast = 1'b0;
  logic        TDC_Ovalid = 1'b0;
  logic        TDC_Oready;
  logic        TDC_INT = 1'b0;
  logic [14:0] TDC_Range = '0;
  logic        rd_en = 1'b0;
  logic [19:0] rd_data;
  logic        rd_empty;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        err_len;
  logic        irq;
  logic        irq_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  tdc_rx_collector #(.DEPTH(8)) dut (
    .clk(clk), .rst_auto(rst_auto),
    .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum),
    .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid), .TDC_Oready(TDC_Oready),
    .TDC_INT(TDC_INT), .TDC_Range(TDC_Range),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .frame_done(frame_done), .frame_cnt(frame_cnt),
    .err_len(err_len), .irq(irq), .irq_clr(irq_clr)
  );

  always #2 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [14:0] d, input logic [3:0] i, input logic [1:0] n, input logic l);
    TDC_Ovalid = 1'b1; TDC_Odata = d; TDC_Oint = i; TDC_Onum = n; TDC_Olast = l;
    tick();
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
  endtask

  task automatic clear_flags();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    tests++; if (TDC_Oready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", TDC_Oready); end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", rd_empty); end
    tests++; if (rd_data !== 20'd0) begin fails++; $display("FAIL rst_data: got %h want 0", rd_data); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", frame_done); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL rst_fcnt: got %0d want 0", frame_cnt); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", err_len); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b want 0", irq); end
    rst_auto = 1'b1;
    #0;
    tests++; if (TDC_Oready !== 1'b0) begin fails++; $display("FAIL rel_ready_pre: got %b want 0", TDC_Oready); end
    tick();
    tests++; if (TDC_Oready !== 1'b1) begin fails++; $display("FAIL rel_ready_post: got %b want 1", TDC_Oready); end
  endtask

  task automatic test_single_beat();
    TDC_Range = 15'h03FC;
    beat(15'h0FFC, 4'd3, 2'd0, 1'b1);
    tests++; if (rd_empty !== 1'b0) begin fails++; $display("FAIL single_empty: got %b want 0", rd_empty); end
    tests++; if (rd_data !== 20'h98FFC) begin fails++; $display("FAIL single_data: got %h want 98ffc", rd_data); end
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL single_done: got %b want 1", frame_done); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", err_len); end
    tick();
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %b want 0", frame_done); end
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL single_fcnt: got %0d want 1", frame_cnt); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL single_pop: got %b want 1", rd_empty); end
  endtask

  task automatic test_four_beat();
    TDC_Range = 15'h7FFF;
    for (int i = 0; i < 4; i++) beat(15'(32'h100 + i), 4'(i), 2'd3, (i == 3));
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL four_done: got %b want 1", frame_done); end
    tick();
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL four_done_pulse: got %b want 0", frame_done); end
    tests++; if (frame_cnt !== 8'd2) begin fails++; $display("FAIL four_fcnt: got %0d want 2", frame_cnt); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL four_err: got %b want 0", err_len); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rd_data !== {1'b0, 4'(i), 15'(32'h100 + i)}) begin fails++; $display("FAIL four_order%0d: got %h want %h", i, rd_data, {1'b0, 4'(i), 15'(32'h100 + i)}); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL four_drain: got %b want 1", rd_empty); end
    for (int i = 0; i < 3; i++) beat(15'(32'h180 + i), 4'd1, 2'd3, (i == 2));
    tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", err_len); end
    tick();
    tests++; if (frame_cnt !== 8'd3) begin fails++; $display("FAIL short_fcnt: got %0d want 3", frame_cnt); end
    rd_en = 1'b1; repeat (3) tick(); rd_en = 1'b0;
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL short_drain: got %b want 1", rd_empty); end
    clear_flags();
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL short_clr: got %b want 0", err_len); end
  endtask

  task automatic test_backpressure();
    TDC_Range = 15'h7FFF;
    TDC_Onum = 2'd0; TDC_Oint = 4'd0; TDC_Olast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      TDC_Ovalid = 1'b1; TDC_Odata = 15'(32'h200 + i);
      tests++; if (TDC_Oready !== 1'b1) begin fails++; $display("FAIL bp_ready%0d: got %b want 1", i, TDC_Oready); end
      tick();
    end
    tests++; if (TDC_Oready !== 1'b0) begin fails++; $display("FAIL bp_full: got %b want 0", TDC_Oready); end
    TDC_Odata = 15'h208; TDC_Olast = 1'b1;
    tick(); tick();
    tests++; if (TDC_Oready !== 1'b0) begin fails++; $display("FAIL bp_held: got %b want 0", TDC_Oready); end
    tests++; if (rd_data !== 20'h00200) begin fails++; $display("FAIL bp_head: got %h want 00200", rd_data); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tests++; if (TDC_Oready !== 1'b1) begin fails++; $display("FAIL bp_reopen: got %b want 1", TDC_Oready); end
    tick();
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
    tests++; if (TDC_Oready !== 1'b0) begin fails++; $display("FAIL bp_ninth: got %b want 0", TDC_Oready); end
    tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL bp_sat_err: got %b want 1", err_len); end
    for (int i = 1; i < 9; i++) begin
      tests++; if (rd_data !== 20'(32'h200 + i)) begin fails++; $display("FAIL bp_order%0d: got %h want %h", i, rd_data, 20'(32'h200 + i)); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL bp_drain: got %b want 1", rd_empty); end
    tests++; if (frame_cnt !== 8'd4) begin fails++; $display("FAIL bp_fcnt: got %0d want 4", frame_cnt); end
    clear_flags();
  endtask

  task automatic test_back_to_back();
    TDC_Onum = 2'd0; TDC_Oint = 4'd0;
    for (int i = 0; i < 10; i++) begin
      TDC_Ovalid = 1'b1; TDC_Odata = 15'(32'h300 + i); TDC_Olast = (i == 9); rd_en = 1'b1;
      tick();
      tests++; if (rd_empty !== 1'b0 || rd_data !== 20'(32'h300 + i)) begin fails++; $display("FAIL b2b_head%0d: got empty=%b data=%h want empty=0 data=%h", i, rd_empty, rd_data, 20'(32'h300 + i)); end
      tests++; if (TDC_Oready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d: got %b want 1", i, TDC_Oready); end
    end
    TDC_Ovalid = 1'b0; TDC_Olast = 1'b0;
    tick();
    rd_en = 1'b0;
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL b2b_occupancy: got empty=%b want 1", rd_empty); end
    tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL b2b_err: got %b want 1", err_len); end
    tests++; if (frame_cnt !== 8'd5) begin fails++; $display("FAIL b2b_fcnt: got %0d want 5", frame_cnt); end
    clear_flags();
  endtask

  task automatic test_wrap_irq();
    for (int f = 0; f < 251; f++) begin
      beat(15'(f), 4'd0, 2'd0, 1'b1);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      if (f == 249) begin
        tests++; if (frame_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
      end
    end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0: got %0d want 0", frame_cnt); end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty: got %b want 1", rd_empty); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b want 0", irq); end
    TDC_INT = 1'b1; tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b want 1", irq); end
    clear_flags();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr_level: got %b want 0", irq); end
    TDC_INT = 1'b0; tick();
    TDC_INT = 1'b1; irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    clear_flags();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clr: got %b want 0", irq); end
    TDC_INT = 1'b0;
  endtask

  task automatic test_oor_boundary();
    TDC_Range = 15'h0100;
    beat(15'h0100, 4'hA, 2'd1, 1'b0);
    beat(15'h0101, 4'h5, 2'd1, 1'b1);
    tick();
    tests++; if (rd_data !== 20'h50100) begin fails++; $display("FAIL oor_equal: got %h want 50100", rd_data); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tests++; if (rd_data !== 20'hA8101) begin fails++; $display("FAIL oor_above: got %h want a8101", rd_data); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL oor_err: got %b want 0", err_len); end
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL oor_fcnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_midframe_reset();
    TDC_Range = 15'h7FFF;
    beat(15'h0400, 4'd1, 2'd3, 1'b0);
    beat(15'h0401, 4'd2, 2'd3, 1'b0);
    rst_auto = 1'b0;
    #1;
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL mid_empty: got %b want 1", rd_empty); end
    tests++; if (frame_cnt !== 8'd0) begin fails++; $display("FAIL mid_fcnt: got %0d want 0", frame_cnt); end
    tests++; if (TDC_Oready !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b want 0", TDC_Oready); end
    tick();
    rst_auto = 1'b1;
    tick();
    beat(15'h0055, 4'd7, 2'd0, 1'b1);
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL mid_done: got %b want 1", frame_done); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL mid_err: got %b want 0", err_len); end
    tests++; if (rd_data !== 20'h38055) begin fails++; $display("FAIL mid_data: got %h want 38055", rd_data); end
    tick();
    tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL mid_fcnt_after: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_four_beat();
    test_backpressure();
    test_back_to_back();
    test_wrap_irq();
    test_oor_boundary();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
